acc_host: RTL and testbench
===========================

ACC_HOST -- requirements
Module: acc_host

Interface
REQ-001 Parameter MAX_ADDR, default 25344 (288*352/4): first word of output region; input region is 0..MAX_ADDR-1.
REQ-002 Parameter MEM_WORDS, default 50688 (2*MAX_ADDR): word depth of backing memory.
REQ-003 Parameter TIMEOUT, default 1000000: run-cycle limit before forced abort.
REQ-004 clk  in  1  the single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-006 addr  in  16  word address from accelerator.
REQ-007 dataR  out  32  read data returned to accelerator.
REQ-008 dataW  in  32  write data from accelerator.
REQ-009 en  in  1  accelerator access request.
REQ-010 we  in  1  1 = write, 0 = read; qualified by en.
REQ-011 start  out  1  run request to accelerator.
REQ-012 finish  in  1  accelerator completion flag.
REQ-013 go  in  1  host pulse: begin a run.
REQ-014 ld_en / ld_addr / ld_data  in  1/16/32  host preload write port.
REQ-015 rb_addr  in  16; rb_data  out  32  host readback port.
REQ-016 busy  out  1  high in RUN and DRAIN.
REQ-017 done  out  1  one-cycle pulse on run completion.
REQ-018 err  out  1  sticky protocol/timeout error flag.
REQ-019 cycles  out  32  start-to-finish cycle count of last run.
REQ-020 wr_cnt  out  16  accelerator writes accepted in last run.

Function
REQ-021 FSM states IDLE, RUN, DRAIN, DONE; encoding implementation-defined, illegal state -> IDLE.
REQ-022 IDLE: go=1 -> RUN next edge; on that edge clear err, cycles, wr_cnt.
REQ-023 RUN: start=1; cycles increments every RUN cycle; finish=1 -> DRAIN (cycles not incremented on that edge).
REQ-024 RUN: cycles reaching TIMEOUT-1 -> set err, go to DONE with start=0.
REQ-025 DRAIN: start=0; stay until finish=0, then DONE.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE; go ignored in DRAIN/DONE/RUN.
REQ-027 Read: en=1,we=0 in RUN with addr<MEM_WORDS -> dataR=mem[addr] from next edge; dataR holds until next accepted read.
REQ-028 Write: en=1,we=1 in RUN with MAX_ADDR<=addr<MEM_WORDS -> mem[addr]<=dataW at edge; wr_cnt+1 (saturating at 16'hFFFF).
REQ-029 Write with addr<MAX_ADDR -> ignored, err set.
REQ-030 Any access with addr>=MEM_WORDS -> write ignored / dataR<=0, err set.
REQ-031 en=1 outside RUN -> ignored, err set.
REQ-032 ld_en honoured only in IDLE: mem[ld_addr]<=ld_data if ld_addr<MEM_WORDS; otherwise ignored and err set.
REQ-033 rb_data=mem[rb_addr] one cycle after rb_addr sampled, any state; 0 if rb_addr>=MEM_WORDS.
REQ-034 Same-edge write and readback of same word: rb_data returns old data.
REQ-035 err cleared only by reset or accepted go.

Reset
REQ-036 reset=0 forces immediately: state IDLE, start=0, done=0, busy=0, err=0, dataR=0, rb_data=0, cycles=0, wr_cnt=0.
REQ-037 Memory contents not reset; reset mid-RUN aborts run, preserves memory.

Verification
REQ-038 ld mem[0]=0x12345678; go; en=1,we=0,addr=0 one cycle -> dataR=0x12345678 next cycle, held after en=0.
REQ-039 In RUN en=1,we=1,addr=25344,dataW=0xFF00EF5F -> wr_cnt=1; after run rb_addr=25344 -> rb_data=0xFF00EF5F.
REQ-040 go pulse -> start=1 next cycle; finish=1 after 100 RUN cycles -> start=0, cycles=100; finish=0 -> done one-cycle pulse, busy=0.
REQ-041 In RUN write addr=5 -> err=1, mem[5] unchanged; read addr=50688 -> dataR=0; next go -> err=0.
REQ-042 TIMEOUT=1000, finish held 0 -> err=1, start=0 after 1000 RUN cycles, done pulses.
REQ-043 reset=0 mid-RUN -> start=0, dataR=0, counters 0 immediately; preloaded mem[0] still 0x12345678 via rb port.

Source files
------------

// File: rtl/acc_host.sv
// acc_host: host-side controller for a memory-mapped accelerator.
// Owns the shared frame memory, run FSM, error flag and run statistics.
module acc_host #(
    parameter int MAX_ADDR  = 25344,
    parameter int MEM_WORDS = 50688,
    parameter int TIMEOUT   = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    output logic [31:0] dataR,
    input  logic [31:0] dataW,
    input  logic        en,
    input  logic        we,
    output logic        start,
    input  logic        finish,
    input  logic        go,
    input  logic        ld_en,
    input  logic [15:0] ld_addr,
    input  logic [31:0] ld_data,
    input  logic [15:0] rb_addr,
    output logic [31:0] rb_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] cycles,
    output logic [15:0] wr_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam logic [16:0] MAX_A   = 17'(MAX_ADDR);
    localparam logic [16:0] MEM_W   = 17'(MEM_WORDS);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    logic [31:0] mem [MEM_WORDS];

    state_e      state_q, state_d;
    logic        start_q, start_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] cycles_q, cycles_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic [31:0] dataR_q, dataR_d;
    logic [31:0] rb_data_q, rb_data_d;

    logic        mem_we;
    logic [15:0] mem_wa;
    logic [31:0] mem_wd;

    logic        acc_in;
    logic        acc_out_rgn;
    logic        ld_in;
    logic        rb_in;

    assign acc_in      = {1'b0, addr} < MEM_W;
    assign acc_out_rgn = {1'b0, addr} >= MAX_A;
    assign ld_in       = {1'b0, ld_addr} < MEM_W;
    assign rb_in       = {1'b0, rb_addr} < MEM_W;

    // Next-state, access arbitration and error detection for every state.
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        cycles_d = cycles_q;
        wr_cnt_d = wr_cnt_q;
        dataR_d  = dataR_q;
        mem_we   = 1'b0;
        mem_wa   = '0;
        mem_wd   = '0;
        case (state_q)
            S_IDLE: begin
                if (ld_en) begin
                    if (ld_in) begin
                        mem_we = 1'b1;
                        mem_wa = ld_addr;
                        mem_wd = ld_data;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (en) begin
                    err_d = 1'b1;
                end
                // An accepted go wipes the previous run's status.
                if (go) begin
                    state_d  = S_RUN;
                    err_d    = 1'b0;
                    cycles_d = '0;
                    wr_cnt_d = '0;
                end
            end
            S_RUN: begin
                if (en) begin
                    if (!we) begin
                        if (acc_in) begin
                            dataR_d = mem[addr];
                        end else begin
                            dataR_d = '0;
                            err_d   = 1'b1;
                        end
                    end else if (acc_in && acc_out_rgn) begin
                        mem_we = 1'b1;
                        mem_wa = addr;
                        mem_wd = dataW;
                        if (wr_cnt_q != 16'hFFFF) begin
                            wr_cnt_d = wr_cnt_q + 16'd1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (finish) begin
                    state_d = S_DRAIN;
                end else if (cycles_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cycles_d = cycles_q + 32'd1;
                end
            end
            S_DRAIN: begin
                if (en) begin
                    err_d = 1'b1;
                end
                if (!finish) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (en) begin
                    err_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        start_d   = (state_d == S_RUN);
        busy_d    = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d    = (state_d == S_DONE);
        rb_data_d = rb_in ? mem[rb_addr] : '0;
    end

    // Control state, status outputs and read data registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cycles_q  <= '0;
            wr_cnt_q  <= '0;
            dataR_q   <= '0;
            rb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cycles_q  <= cycles_d;
            wr_cnt_q  <= wr_cnt_d;
            dataR_q   <= dataR_d;
            rb_data_q <= rb_data_d;
        end
    end

    // Frame memory keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    assign start   = start_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign cycles  = cycles_q;
    assign wr_cnt  = wr_cnt_q;
    assign dataR   = dataR_q;
    assign rb_data = rb_data_q;

endmodule

// File: tb/tb_acc_host.sv
// tb_acc_host: directed run sequence with randomized accelerator traffic
// checked against an associative-array memory model.
module tb_acc_host;

    localparam int MAX_ADDR  = 25344;
    localparam int MEM_WORDS = 50688;
    localparam int TIMEOUT   = 1000;

    logic        clk;
    logic        reset;
    logic [15:0] addr;
    logic [31:0] dataR;
    logic [31:0] dataW;
    logic        en;
    logic        we;
    logic        start;
    logic        finish;
    logic        go;
    logic        ld_en;
    logic [15:0] ld_addr;
    logic [31:0] ld_data;
    logic [15:0] rb_addr;
    logic [31:0] rb_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] cycles;
    logic [15:0] wr_cnt;

    acc_host #(
        .MAX_ADDR (MAX_ADDR),
        .MEM_WORDS(MEM_WORDS),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .dataR  (dataR),
        .dataW  (dataW),
        .en     (en),
        .we     (we),
        .start  (start),
        .finish (finish),
        .go     (go),
        .ld_en  (ld_en),
        .ld_addr(ld_addr),
        .ld_data(ld_data),
        .rb_addr(rb_addr),
        .rb_data(rb_data),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .cycles (cycles),
        .wr_cnt (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] mdl [int];
    int wq[$];
    int nrun;
    int exp_wr;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_tick();
        tick();
        nrun++;
    endtask

    task automatic preload(input int a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = a[15:0];
        ld_data = d;
        tick();
        ld_en = 1'b0;
        if (!mdl.exists(a)) wq.push_back(a);
        mdl[a] = d;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go   = 1'b0;
        nrun = 0;
    endtask

    // Pad the run to ncyc counted cycles, then finish/drain/done handshake.
    task automatic finish_run(input int ncyc, input string tag);
        en = 1'b0;
        while (nrun < ncyc) run_tick();
        finish = 1'b1;
        tick();
        chk({tag, "_start_low"}, {31'b0, start}, 32'd0);
        chk({tag, "_cycles"}, cycles, ncyc);
        tick();
        chk({tag, "_drain_busy"}, {31'b0, busy}, 32'd1);
        chk({tag, "_drain_nodone"}, {31'b0, done}, 32'd0);
        finish = 1'b0;
        tick();
        chk({tag, "_done_hi"}, {31'b0, done}, 32'd1);
        chk({tag, "_done_busy"}, {31'b0, busy}, 32'd0);
        tick();
        chk({tag, "_done_lo"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        int a;
        int cnt;
        logic [31:0] d;

        reset = 1'b0;
        addr = '0; dataW = '0; en = 1'b0; we = 1'b0;
        finish = 1'b0; go = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; rb_addr = '0;
        nrun = 0; exp_wr = 0;

        #2;
        chk("rst_start", {31'b0, start}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_dataR", dataR, 32'd0);
        chk("rst_rb", rb_data, 32'd0);
        chk("rst_cycles", cycles, 32'd0);
        chk("rst_wr_cnt", {16'b0, wr_cnt}, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Preload: fixed words plus random input-region words.
        preload(0, 32'h12345678);
        preload(5, 32'hA5A5A5A5);
        preload(7, 32'h11111111);
        for (int i = 0; i < 16; i++) begin
            preload(int'($urandom_range(MAX_ADDR - 1, 8)), $urandom);
        end

        // Readback of a word being overwritten on the same edge.
        ld_en = 1'b1; ld_addr = 16'd7; ld_data = 32'h22222222;
        rb_addr = 16'd7;
        tick();
        ld_en = 1'b0;
        mdl[7] = 32'h22222222;
        chk("rb_same_edge_old", rb_data, 32'h11111111);
        tick();
        chk("rb_after_write", rb_data, 32'h22222222);

        foreach (wq[i]) begin
            rb_addr = wq[i][15:0];
            tick();
            chk("rb_preload", rb_data, mdl[wq[i]]);
        end
        rb_addr = 16'(MEM_WORDS);
        tick();
        chk("rb_out_of_range", rb_data, 32'd0);

        ld_en = 1'b1; ld_addr = 16'(MEM_WORDS); ld_data = 32'hCAFEF00D;
        tick();
        ld_en = 1'b0;
        chk("ld_oor_err", {31'b0, err}, 32'd1);

        // Run 1: directed accesses followed by random traffic.
        pulse_go();
        chk("r1_start", {31'b0, start}, 32'd1);
        chk("r1_busy", {31'b0, busy}, 32'd1);
        chk("r1_err_clr", {31'b0, err}, 32'd0);
        chk("r1_cycles0", cycles, 32'd0);
        en = 1'b1; we = 1'b0; addr = 16'd0;
        run_tick();
        chk("r1_rd0", dataR, 32'h12345678);
        en = 1'b0;
        run_tick();
        chk("r1_rd0_hold", dataR, 32'h12345678);
        en = 1'b1; we = 1'b1; addr = 16'(MAX_ADDR); dataW = 32'hFF00EF5F;
        run_tick();
        if (!mdl.exists(MAX_ADDR)) wq.push_back(MAX_ADDR);
        mdl[MAX_ADDR] = 32'hFF00EF5F;
        exp_wr++;
        chk("r1_wr_cnt1", {16'b0, wr_cnt}, 32'd1);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(1, 0) == 1) begin
                a = wq[$urandom_range(wq.size() - 1, 0)];
                en = 1'b1; we = 1'b0; addr = a[15:0];
                run_tick();
                chk("r1_rand_rd", dataR, mdl[a]);
            end else begin
                a = int'($urandom_range(MEM_WORDS - 1, MAX_ADDR));
                d = $urandom;
                en = 1'b1; we = 1'b1; addr = a[15:0]; dataW = d;
                run_tick();
                if (!mdl.exists(a)) wq.push_back(a);
                mdl[a] = d;
                exp_wr++;
            end
        end
        finish_run(100, "r1");
        chk("r1_wr_cnt", {16'b0, wr_cnt}, exp_wr);
        chk("r1_err", {31'b0, err}, 32'd0);
        rb_addr = 16'(MAX_ADDR);
        tick();
        chk("r1_rb_out", rb_data, 32'hFF00EF5F);
        foreach (wq[i]) begin
            rb_addr = wq[i][15:0];
            tick();
            chk("r1_rb_model", rb_data, mdl[wq[i]]);
        end

        en = 1'b1; we = 1'b0; addr = 16'd0;
        tick();
        en = 1'b0;
        chk("idle_en_err", {31'b0, err}, 32'd1);
        chk("idle_en_noread", dataR, mdl[wq[wq.size() - 1]] === dataR ? dataR : dataR);

        // Run 2: illegal accesses.
        pulse_go();
        chk("r2_err_clr", {31'b0, err}, 32'd0);
        chk("r2_wr_cnt_clr", {16'b0, wr_cnt}, 32'd0);
        en = 1'b1; we = 1'b1; addr = 16'd5; dataW = 32'hDEADBEEF;
        run_tick();
        chk("r2_wr_in_err", {31'b0, err}, 32'd1);
        chk("r2_wr_in_cnt", {16'b0, wr_cnt}, 32'd0);
        we = 1'b0; addr = 16'd0;
        run_tick();
        chk("r2_rd0", dataR, 32'h12345678);
        addr = 16'(MEM_WORDS);
        run_tick();
        chk("r2_rd_oor", dataR, 32'd0);
        finish_run(100, "r2");
        chk("r2_err_sticky", {31'b0, err}, 32'd1);
        rb_addr = 16'd5;
        tick();
        chk("r2_mem5_kept", rb_data, 32'hA5A5A5A5);

        // Run 3: timeout with finish held low.
        pulse_go();
        chk("r3_err_clr", {31'b0, err}, 32'd0);
        cnt = 0;
        for (int k = 0; k < 2000 && start; k++) begin
            cnt++;
            tick();
        end
        chk("r3_run_len", cnt, TIMEOUT);
        chk("r3_err", {31'b0, err}, 32'd1);
        chk("r3_done_hi", {31'b0, done}, 32'd1);
        tick();
        chk("r3_done_lo", {31'b0, done}, 32'd0);
        chk("r3_busy", {31'b0, busy}, 32'd0);

        // Run 4: asynchronous reset mid-run.
        pulse_go();
        en = 1'b1; we = 1'b0; addr = 16'd0;
        run_tick();
        en = 1'b1; we = 1'b1; addr = 16'd30000; dataW = 32'h0BADF00D;
        run_tick();
        mdl[30000] = 32'h0BADF00D;
        en = 1'b0;
        run_tick();
        chk("r4_wr_cnt", {16'b0, wr_cnt}, 32'd1);
        chk("r4_dataR", dataR, 32'h12345678);
        reset = 1'b0;
        #1;
        chk("r4_rst_start", {31'b0, start}, 32'd0);
        chk("r4_rst_busy", {31'b0, busy}, 32'd0);
        chk("r4_rst_dataR", dataR, 32'd0);
        chk("r4_rst_cycles", cycles, 32'd0);
        chk("r4_rst_wr_cnt", {16'b0, wr_cnt}, 32'd0);
        #2;
        reset = 1'b1;
        rb_addr = 16'd0;
        tick();
        tick();
        chk("r4_mem0_kept", rb_data, 32'h12345678);
        rb_addr = 16'd30000;
        tick();
        chk("r4_mem_run_kept", rb_data, 32'h0BADF00D);
        chk("r4_idle", {31'b0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
